// File: rtl/enc_gen_pkg.sv
// Shared types and constants for the quadrature encoder signal generator.
// The FSM encoding, the gray phase table and the direction constants live here so other generators can use them.
package enc_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EDGE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Element n is the Enc value for phase n: 00, 01, 11, 10.
  localparam logic [3:0][1:0] GRAY_TBL = {2'b10, 2'b11, 2'b01, 2'b00};

  function automatic logic [1:0] phase_to_enc(input logic [1:0] phase);
    return GRAY_TBL[phase];
  endfunction

endpackage

// File: rtl/enc_phase_step.sv
// Moves a quadrature phase one step in the commanded direction and returns the new phase and its gray-coded A/B value.
// The block is combinational, so one copy can sit next to each axis of a multi-axis generator.
module enc_phase_step
  import enc_gen_pkg::*;
(
  input  logic [1:0] i_phase,
  input  logic       i_dir,
  output logic [1:0] o_phase,
  output logic [1:0] o_enc
);

  // NOTE: every output of an always_comb block is assigned a default at the top.
  // That way no path through the block can leave a value unassigned and infer a latch.
  always_comb begin
    o_phase = i_phase;
    case (i_dir)
      DIR_UP: o_phase = i_phase + 2'd1;
      DIR_DN: o_phase = i_phase - 2'd1;
    endcase
    o_enc = phase_to_enc(o_phase);
  end

endmodule

// File: rtl/quad_enc_gen.sv
// Quadrature encoder signal generator: turns step commands into A/B quadrature, an index pulse and a position count.
// Define ENC_GEN_INDEX_EN to build the revolution counter that drives Enc_I. Without it, Enc_I is tied low.
module quad_enc_gen
  import enc_gen_pkg::*;
#(
  parameter int MIN_PERIOD = 2,
  parameter int CPR        = 1024,
  parameter int POS_W      = 18
) (
  input  logic             Clk,
  input  logic             Clr_n,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic             Cmd_Dir,
  input  logic [15:0]      Cmd_Steps,
  input  logic [15:0]      Cmd_Period,
  input  logic             Abort,
  output logic [1:0]       Enc,
  output logic             Enc_I,
  output logic [POS_W-1:0] Position,
  output logic             Busy,
  output logic             Done
);

  if (MIN_PERIOD < 2 || CPR < 2) begin : g_param_check
    $error("quad_enc_gen: MIN_PERIOD and CPR must both be at least 2");
  end

  localparam logic [15:0] MIN_PER16 = 16'(MIN_PERIOD);

  state_t           r_state;
  logic             r_dir;
  logic [15:0]      r_remaining;
  logic [15:0]      r_per;
  logic [15:0]      r_wait;
  logic [1:0]       r_phase;
  logic [1:0]       r_enc;
  logic [POS_W-1:0] r_pos;
  logic             r_done;

  logic             w_accept;
  logic             w_do_step;
  logic             w_step_dir;
  logic [15:0]      w_per;
  logic [1:0]       w_next_phase;
  logic [1:0]       w_next_enc;

  assign w_accept   = Cmd_Valid && (r_state == ST_IDLE);
  assign w_step_dir = (r_state == ST_IDLE) ? Cmd_Dir : r_dir;
  assign w_per      = (Cmd_Period < MIN_PER16) ? MIN_PER16 : Cmd_Period;

  // The phase advances on the clock edge that enters EDGE, so the output changes in the first cycle of EDGE.
  // Abort takes priority over the step that would end a WAIT, which keeps Enc at its last value.
  assign w_do_step = (w_accept && (Cmd_Steps != 16'd0)) ||
                     ((r_state == ST_WAIT) && !Abort && (r_wait == 16'd0) &&
                      (r_remaining != 16'd0));

  enc_phase_step u_step (
    .i_phase (r_phase),
    .i_dir   (w_step_dir),
    .o_phase (w_next_phase),
    .o_enc   (w_next_enc)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  // Each register then sees the values from before the clock edge, regardless of statement order.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      r_state     <= ST_IDLE;
      r_dir       <= DIR_UP;
      r_remaining <= '0;
      r_per       <= MIN_PER16;
      r_wait      <= '0;
      r_phase     <= '0;
      r_enc       <= 2'b00;
      r_pos       <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_do_step) begin
        r_phase <= w_next_phase;
        r_enc   <= w_next_enc;
        r_pos   <= (w_step_dir == DIR_UP) ? r_pos + 1'b1 : r_pos - 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (Cmd_Valid) begin
            if (Cmd_Steps == 16'd0) begin
              r_done <= 1'b1;
            end else begin
              r_dir       <= Cmd_Dir;
              // The first transition is emitted on this same edge.
              r_remaining <= Cmd_Steps - 16'd1;
              r_per       <= w_per;
              r_state     <= ST_EDGE;
            end
          end
        end

        ST_EDGE: begin
          if (Abort) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            // The EDGE cycle and the WAIT exit cycle take two clocks of the period.
            r_wait  <= r_per - 16'd2;
            r_state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (Abort) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (r_wait != 16'd0) begin
            r_wait <= r_wait - 16'd1;
          end else if (r_remaining != 16'd0) begin
            r_remaining <= r_remaining - 16'd1;
            r_state     <= ST_EDGE;
          end else begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ENC_GEN_INDEX_EN
  localparam int              REV_W   = $clog2(CPR);
  localparam logic [REV_W-1:0] REV_MAX = REV_W'(CPR - 1);

  logic [REV_W-1:0] r_rev;
  logic [REV_W-1:0] w_rev_next;
  logic             r_enc_i;

  always_comb begin
    w_rev_next = r_rev;
    if (w_step_dir == DIR_UP) begin
      w_rev_next = (r_rev == REV_MAX) ? '0 : r_rev + 1'b1;
    end else begin
      w_rev_next = (r_rev == '0) ? REV_MAX : r_rev - 1'b1;
    end
  end

  // The index flop updates on the same edge as Enc, so Enc_I is high for exactly one quadrature count.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      r_rev   <= '0;
      r_enc_i <= 1'b1;
    end else if (w_do_step) begin
      r_rev   <= w_rev_next;
      r_enc_i <= (w_rev_next == '0);
    end
  end

  assign Enc_I = r_enc_i;
`else
  assign Enc_I = 1'b0;
`endif

  assign Enc       = r_enc;
  assign Position  = r_pos;
  assign Busy      = (r_state != ST_IDLE);
  assign Cmd_Ready = (r_state == ST_IDLE);
  assign Done      = r_done;

endmodule

// File: tb/tb_quad_enc_gen.sv
// Bench for quad_enc_gen. A driver issues commands and queues the expected Enc and Done events from a behavioural model.
// A monitor pops the queue and compares each event as it appears on the DUT outputs.
module tb_quad_enc_gen;

  localparam int MIN_PERIOD = 2;
  localparam int CPR        = 8;
  localparam int POS_W      = 18;
`ifdef ENC_GEN_INDEX_EN
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Clr_n = 1'b0;
  logic             Cmd_Valid = 1'b0;
  logic             Cmd_Ready;
  logic             Cmd_Dir = 1'b0;
  logic [15:0]      Cmd_Steps = '0;
  logic [15:0]      Cmd_Period = '0;
  logic             Abort = 1'b0;
  logic [1:0]       Enc;
  logic             Enc_I;
  logic [POS_W-1:0] Position;
  logic             Busy;
  logic             Done;

  quad_enc_gen #(.MIN_PERIOD(MIN_PERIOD), .CPR(CPR), .POS_W(POS_W)) dut (
    .Clk        (Clk),
    .Clr_n      (Clr_n),
    .Cmd_Valid  (Cmd_Valid),
    .Cmd_Ready  (Cmd_Ready),
    .Cmd_Dir    (Cmd_Dir),
    .Cmd_Steps  (Cmd_Steps),
    .Cmd_Period (Cmd_Period),
    .Abort      (Abort),
    .Enc        (Enc),
    .Enc_I      (Enc_I),
    .Position   (Position),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  typedef struct {
    int               cyc;
    bit               is_done;
    logic [1:0]       enc;
    logic [POS_W-1:0] pos;
    logic             enc_i;
  } ev_t;

  ev_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference model: position as plain modular arithmetic, rotation as a count modulo CPR.
  int               m_phase = 0;
  int               m_rev   = 0;
  logic [POS_W-1:0] m_pos   = '0;
  logic [1:0]       m_gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic logic m_index();
    return IDX_EN ? (m_rev == 0) : 1'b0;
  endfunction

  task automatic model_step(input bit dir);
    m_phase = dir ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
    m_rev   = dir ? (m_rev + 1) % CPR : (m_rev + CPR - 1) % CPR;
    m_pos   = dir ? m_pos + 1'b1 : m_pos - 1'b1;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_rev   = 0;
    m_pos   = '0;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic on_event(input bit is_done);
    ev_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_%s: got an event at cycle %0d, want none",
               is_done ? "done" : "enc_change", cyc);
      return;
    end
    e = sb_q.pop_front();
    check(is_done ? "kind_done" : "kind_enc", longint'(is_done), longint'(e.is_done));
    check("event_cycle", longint'(cyc), longint'(e.cyc));
    check("enc", longint'(Enc), longint'(e.enc));
    check("position", longint'(Position), longint'(e.pos));
    check("enc_i", longint'(Enc_I), longint'(e.enc_i));
    check("busy", longint'(Busy), longint'(!e.is_done));
    check("cmd_ready", longint'(Cmd_Ready), longint'(e.is_done));
  endtask

  // Monitor: any Enc change or Done pulse seen at the falling edge is one output event.
  logic [1:0] prev_enc = 2'b00;
  initial begin
    forever begin
      @(negedge Clk);
      if (!Clr_n) begin
        prev_enc = Enc;
      end else begin
        if (Enc !== prev_enc) on_event(1'b0);
        if (Done === 1'b1) on_event(1'b1);
        prev_enc = Enc;
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 200 && Cmd_Ready !== 1'b1; i++) @(negedge Clk);
    if (Cmd_Ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got Cmd_Ready=%b after 200 cycles, want 1", Cmd_Ready);
    end
  endtask

  // Issues one command at a falling edge and queues every event it should produce.
  // An abort lands j cycles after the k-th transition becomes visible.
  task automatic issue(input bit dir, input int steps, input int period,
                       input bit do_abort, input int ab_k, input int ab_j, input bit ab_coinc);
    int a, per, n_chg, done_at, abort_at;
    ev_t e;
    wait_ready();
    Cmd_Valid  = 1'b1;
    Cmd_Dir    = dir;
    Cmd_Steps  = 16'(steps);
    Cmd_Period = 16'(period);
    Abort      = ab_coinc;
    a   = cyc + 1;
    per = (period < MIN_PERIOD) ? MIN_PERIOD : period;
    abort_at = -1;
    if (steps == 0) begin
      n_chg   = 0;
      done_at = a;
    end else if (do_abort) begin
      n_chg    = ab_k;
      done_at  = a + (ab_k - 1) * per + ab_j + 1;
      abort_at = done_at - 1;
    end else begin
      n_chg   = steps;
      done_at = a + steps * per;
    end
    for (int k = 0; k < n_chg; k++) begin
      model_step(dir);
      e = '{cyc: a + k * per, is_done: 1'b0, enc: m_gray[m_phase], pos: m_pos, enc_i: m_index()};
      sb_q.push_back(e);
    end
    e = '{cyc: done_at, is_done: 1'b1, enc: m_gray[m_phase], pos: m_pos, enc_i: m_index()};
    sb_q.push_back(e);
    do begin
      @(negedge Clk);
      Cmd_Valid  = 1'b0;
      Cmd_Dir    = 1'($urandom);
      Cmd_Steps  = 16'($urandom);
      Cmd_Period = 16'($urandom);
      Abort      = (cyc == abort_at);
    end while (cyc < done_at);
    Abort = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, steps, per, k, j;
    bit ab;

    #12;
    check("rst_enc", longint'(Enc), 0);
    check("rst_position", longint'(Position), 0);
    check("rst_enc_i", longint'(Enc_I), longint'(IDX_EN));
    check("rst_ready", longint'(Cmd_Ready), 1);
    check("rst_busy", longint'(Busy), 0);
    check("rst_done", longint'(Done), 0);
    #2 Clr_n = 1'b1;
    @(negedge Clk);

    issue(1'b0, 1, 4, 1'b0, 0, 0, 1'b0);     // reverse from reset: position wraps to all ones
    issue(1'b1, 1, 3, 1'b0, 0, 0, 1'b0);
    issue(1'b1, 4, 4, 1'b0, 0, 0, 1'b0);     // edges at +0/4/8/12, Done at +16
    issue(1'b0, 3, 0, 1'b0, 0, 0, 1'b0);     // period clamped up to MIN_PERIOD
    issue(1'b0, 1, 2, 1'b0, 0, 0, 1'b0);
    issue(1'b1, 8, 2, 1'b0, 0, 0, 1'b0);     // one full revolution
    issue(1'b0, 1, 5, 1'b0, 0, 0, 1'b0);
    issue(1'b1, 1, 2, 1'b0, 0, 0, 1'b0);
    issue(1'b1, 10, 3, 1'b1, 3, 0, 1'b0);    // abort during the third EDGE
    issue(1'b1, 0, 5, 1'b0, 0, 0, 1'b0);     // zero steps: Done only
    issue(1'b0, 2, 3, 1'b0, 0, 0, 1'b1);     // abort coinciding with accept is ignored
    issue(1'b1, 2, 0, 1'b1, 2, 1, 1'b0);     // abort on the cycle the command would end anyway

    for (int n = 0; n < 40; n++) begin
      steps = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 9));
      per   = int'($urandom_range(0, 6));
      ab    = (steps != 0) && ($urandom_range(0, 3) == 0);
      k     = (steps != 0) ? int'($urandom_range(1, steps)) : 0;
      j     = int'($urandom_range(0, ((per < MIN_PERIOD) ? MIN_PERIOD : per) - 1));
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      issue(1'($urandom), steps, per, ab, k, j, 1'($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of a long WAIT.
    wait_ready();
    Cmd_Valid  = 1'b1;
    Cmd_Dir    = 1'b1;
    Cmd_Steps  = 16'd5;
    Cmd_Period = 16'd20;
    a = cyc + 1;
    model_step(1'b1);
    sb_q.push_back('{cyc: a, is_done: 1'b0, enc: m_gray[m_phase], pos: m_pos, enc_i: m_index()});
    @(negedge Clk);
    Cmd_Valid = 1'b0;
    repeat (5) @(negedge Clk);
    check("pre_rst_busy", longint'(Busy), 1);
    #3 Clr_n = 1'b0;
    #1;
    check("async_rst_enc", longint'(Enc), 0);
    check("async_rst_position", longint'(Position), 0);
    check("async_rst_enc_i", longint'(Enc_I), longint'(IDX_EN));
    check("async_rst_ready", longint'(Cmd_Ready), 1);
    check("async_rst_busy", longint'(Busy), 0);
    check("async_rst_done", longint'(Done), 0);
    check("sb_empty_before_rst", longint'(sb_q.size()), 0);
    sb_q.delete();
    model_reset();
    repeat (2) @(negedge Clk);
    #2 Clr_n = 1'b1;
    @(negedge Clk);
    issue(1'b1, 3, 3, 1'b0, 0, 0, 1'b0);

    repeat (4) @(negedge Clk);
    check("sb_drained", longint'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
